// File: rtl/sequence_serializer.sv
// Parallel-to-serial feeder for the 1011 sequence detector: valid/ready word input,
// one-word holding register for gapless streaming, registered serial line and framing strobes.
module sequence_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_active,
  output logic             word_start,
  output logic             underrun
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hold_valid_q;
  logic             serial_q;
  logic             active_q;
  logic             start_q;
  logic             underrun_q;

  logic             accept;
  logic             at_last;
  logic             load_d;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] sh_d;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Accept never depends on anything but a flag and in_valid, so in_ready stays flop-only.
  assign accept  = in_valid && !hold_valid_q;
  assign at_last = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_d  = ((state_q == IDLE) && accept) || (at_last && (hold_valid_q || accept));
  assign word_d  = hold_valid_q ? hold_q : in_data;
  assign sh_d    = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sh/hold are reset too even though they are discarded; keeps simulation X-free.
      state_q      <= IDLE;
      sh_q         <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      serial_q     <= IDLE_BIT;
      active_q     <= 1'b0;
      start_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      // NOTE: strobes default low each edge and are raised only where they apply; non-blocking keeps ordering irrelevant.
      start_q    <= 1'b0;
      underrun_q <= 1'b0;

      if (load_d && hold_valid_q) begin
        hold_valid_q <= 1'b0;
      end else if (accept && !load_d) begin
        hold_q       <= in_data;
        hold_valid_q <= 1'b1;
      end

      if (load_d) begin
        state_q  <= SHIFT;
        sh_q     <= word_d;
        cnt_q    <= '0;
        serial_q <= first_bit(word_d);
        active_q <= 1'b1;
        start_q  <= 1'b1;
      end else if (state_q == SHIFT && !at_last) begin
        sh_q     <= sh_d;
        cnt_q    <= cnt_q + 1'b1;
        serial_q <= first_bit(sh_d);
      end else if (at_last) begin
        state_q    <= IDLE;
        serial_q   <= IDLE_BIT;
        active_q   <= 1'b0;
        underrun_q <= 1'b1;
      end
    end
  end

  assign in_ready      = !hold_valid_q;
  assign serial_out    = serial_q;
  assign serial_active = active_q;
  assign word_start    = start_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sequence_serializer.sv
// Directed bench for sequence_serializer: MSB-first and LSB-first instances, reset behaviour,
// back-to-back streaming and a behavioural 1011 Moore detector fed by the serial line.
module tb_sequence_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, serial_out, serial_active, word_start, underrun;
  logic [7:0] in_data_l;
  logic       in_valid_l;
  logic       in_ready_l, serial_out_l, serial_active_l, word_start_l, underrun_l;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wl [0:2];
  int         wn;

  sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_out(serial_out), .serial_active(serial_active),
    .word_start(word_start), .underrun(underrun)
  );

  sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .serial_out(serial_out_l), .serial_active(serial_active_l),
    .word_start(word_start_l), .underrun(underrun_l)
  );

  always #5 clock = ~clock;

  // Overlapping Moore 1011 detector consuming the serial line.
  typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_t;
  det_t det_q;
  logic det_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) det_q <= D0;
    else begin
      case (det_q)
        D0:      det_q <= serial_out ? D1 : D0;
        D1:      det_q <= serial_out ? D1 : D2;
        D2:      det_q <= serial_out ? D3 : D0;
        D3:      det_q <= serial_out ? D4 : D2;
        default: det_q <= serial_out ? D1 : D2;
      endcase
    end
  end
  assign det_out = (det_q == D4);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"},    serial_out,    1'b0);
    check({tag, "_active"}, serial_active, 1'b0);
    check({tag, "_start"},  word_start,    1'b0);
    check({tag, "_under"},  underrun,      1'b0);
    check({tag, "_ready"},  in_ready,      1'b1);
  endtask

  function automatic logic exp_bit(input int j);
    logic [7:0] w;
    w = wl[j / 8];
    return w[7 - (j % 8)];
  endfunction

  // Streams wl[0..wn-1] with in_valid held high; cycle j is the one after edge k+j.
  task automatic run_stream(input string tag, input bit chk_det);
    bit  acc;
    bit  exp_det;
    int  widx = 0;
    int  pulses = 0;
    in_data  = wl[0];
    in_valid = 1'b1;
    for (int j = 0; j <= wn * 8; j++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        widx++;
        if (widx < wn) in_data = wl[widx];
        else in_valid = 1'b0;
      end
      if (j < wn * 8) begin
        check({tag, "_bit"},    serial_out,    exp_bit(j));
        check({tag, "_active"}, serial_active, 1'b1);
        check({tag, "_start"},  word_start,    (j % 8) == 0);
        check({tag, "_under"},  underrun,      1'b0);
        check({tag, "_ready"},  in_ready,      !(((j % 8) != 0) && ((j / 8) < wn - 1)));
      end else begin
        check({tag, "_end_out"},    serial_out,    1'b0);
        check({tag, "_end_active"}, serial_active, 1'b0);
        check({tag, "_end_under"},  underrun,      1'b1);
        check({tag, "_end_ready"},  in_ready,      1'b1);
      end
      if (chk_det) begin
        exp_det = (j >= 4) && exp_bit(j - 4) && !exp_bit(j - 3) && exp_bit(j - 2) && exp_bit(j - 1);
        check({tag, "_det"}, det_out, exp_det);
        if (det_out) pulses++;
      end
    end
    tick();
    check({tag, "_under_clear"}, underrun, 1'b0);
    if (chk_det) check({tag, "_det_pulses"}, pulses, 3);
  endtask

  initial begin
    logic [7:0] lsb_exp;
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_data_l  = '0;
    in_valid_l = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check_idle("rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("rst_rel");
    end

    // Single word, MSB first
    wl[0] = 8'hB0;
    wn    = 1;
    run_stream("single", 1'b0);

    // Back-to-back three words
    wl[0] = 8'hB5;
    wl[1] = 8'h6D;
    wl[2] = 8'hFF;
    wn    = 3;
    run_stream("b2b", 1'b0);

    // LSB first
    lsb_exp    = 8'b1011_0000;
    in_data_l  = 8'h0D;
    in_valid_l = 1'b1;
    tick();
    in_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit",   serial_out_l,    lsb_exp[7 - i]);
      check("lsb_start", word_start_l,    i == 0);
      check("lsb_active", serial_active_l, 1'b1);
      tick();
    end
    check("lsb_end_out",   serial_out_l, 1'b0);
    check("lsb_end_under", underrun_l,   1'b1);

    // Reset mid-word with a second word waiting in hold
    tick();
    in_data  = 8'hB5;
    in_valid = 1'b1;
    tick();
    in_data = 8'h6D;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_bit3",  serial_out, 1'b1);
    check("mid_ready", in_ready,   1'b0);
    reset = 1'b1;
    #1;
    check_idle("mid_rst");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_rst");
    end
    wl[0] = 8'h3C;
    wn    = 1;
    run_stream("post_word", 1'b0);

    // Gapless stream into the 1011 detector
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    wl[0] = 8'hB5;
    wl[1] = 8'h6D;
    wn    = 2;
    run_stream("integ", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sequence_serializer.md
# sequence_serializer

Upstream feeder for the Moore 1011 sequence detector. Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a registered serial line that drives the detector's `sequence_in` directly. A one-word holding register lets consecutive words stream with no idle gap. Framing strobes (`word_start`, `serial_active`, `underrun`) are provided for monitoring and scoreboarding.

## Interface
- `WIDTH`, default 8: parallel word width in bits, ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `serial_out` when no word is being shifted.
- Reset is `reset`, asynchronous, active-high. Clock is `clock`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  parallel word, sampled on accept.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block can accept a word this cycle. Equal to `!hold_valid`, a registered-only function.
- `serial_out`  out  1  registered serial bit, connects to the detector's `sequence_in`.
- `serial_active`  out  1  high while `serial_out` carries a data bit.
- `word_start`  out  1  high during the first bit of each word.
- `underrun`  out  1  one-cycle pulse when the stream goes idle after a word.

## Operation
- Internal state:
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt` (width clog2(WIDTH))
  - holding register `hold` with flag `hold_valid`
  - FSM state `IDLE` or `SHIFT`
- Accept condition: `in_valid && in_ready` at a rising edge. Words offered while `in_ready=0` are not taken; the producer holds `in_data` stable until accepted.
- Routing of an accepted word:
  - If the FSM is in `IDLE`, or in `SHIFT` with `cnt==WIDTH-1` (last bit showing), the word loads straight into `sh`.
  - Otherwise the word goes to `hold` and `hold_valid` is set.
- In `SHIFT` with `cnt==WIDTH-1`:
  - If `hold_valid`, load `sh<=hold`, clear `hold_valid`, set `cnt<=0`, and stay in `SHIFT` (gapless).
  - Else, if a word is accepted this edge, it loads as above and the FSM stays in `SHIFT`.
  - Else, go to `IDLE` and pulse `underrun` for one cycle.
- In `SHIFT` otherwise: shift `sh` one position toward the output end and set `cnt<=cnt+1`.
- `serial_out` is registered:
  - On a load edge it takes the first bit of the new word.
  - On a shift edge it takes the next bit.
  - On entry to `IDLE` it takes `IDLE_BIT`.
- `serial_active` is 1 in every cycle `serial_out` shows a data bit. `word_start` is 1 only in the first-bit cycle.
- Simultaneous hold drain and new offer: cannot occur, because `in_ready` is 0 while `hold_valid` is set. `in_ready` rises the cycle after `hold` drains.
- Reset, at any time including mid-word:
  - `sh`, `cnt` and `hold` are discarded, `hold_valid=0`, FSM goes to `IDLE`.
  - Outputs go immediately to: `serial_out=IDLE_BIT`, `serial_active=0`, `word_start=0`, `underrun=0`, `in_ready=1`.
  - No partial word resumes after reset.
- Idle bits between words are seen by the detector. With `IDLE_BIT=0`, a pattern split across a gap may be broken; only gapless streaming preserves cross-word matches.

## Timing
- Latency: a word accepted at edge k (FSM in `IDLE`) shows its first bit on `serial_out` from edge k until edge k+1. Bit i occupies the cycle after edge k+i.
- One word takes exactly WIDTH cycles on the line.
- Throughput: one word per WIDTH cycles, sustained, when the producer keeps `in_valid` high.
- `in_ready` after reset: 1. It falls the cycle after a word enters `hold` and rises the cycle after `hold` loads into `sh`.
- `underrun` is high during the first `IDLE_BIT` cycle after the last data bit.
- Every output is a flop or a function of flops only. There is no combinational path from the inputs to any output.

## Test plan
- **Reset values:** hold `reset` high, then release, with `in_valid=0` → `serial_out=0`, `in_ready=1`, `serial_active=0`, `word_start=0`, `underrun=0` for 10 cycles.
- **Single word, MSB first:** `in_data=8'hB0` accepted at edge k → `serial_out`=1,0,1,1,0,0,0,0 in cycles k..k+7 with `word_start` high in cycle k only. Cycle k+8: `serial_out=0`, `underrun=1`, `serial_active=0`.
- **Back-to-back:** `8'hB5`, `8'h6D`, `8'hFF` offered continuously → 24 contiguous data bits with no gap, `word_start` every 8 cycles, `in_ready` low while `hold` is full, a single `underrun` after bit 24.
- **LSB first:** `MSB_FIRST=0`, `in_data=8'h0D` → `serial_out`=1,0,1,1,0,0,0,0.
- **Reset mid-operation:** assert `reset` during bit 3 of `8'hB5` with a second word in `hold` → outputs return to reset values in the same cycle. After release there is no residual data on `serial_out`, and the next accepted word starts at bit 0.
- **Integration with detector:** words `8'hB5`, `8'h6D` streamed gapless into the 1011 Moore detector → `detector_out` pulses exactly at the stream positions where a 1011 completes, checked against a bit-level reference model of the concatenated stream.
